// File: rtl/slip_counter_pkg.sv
// Shared types and constants for the Slipstream programmable sync counter.
package slip_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] MODE_STOP    = 2'b00;
   localparam logic [1:0] MODE_FREE    = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   // Reserved mode 2'b11 behaves like stop, so only free-run and one-shot are active.
   function automatic logic mode_active(input logic [1:0] mode);
      return (mode == MODE_FREE) || (mode == MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/sync_cnt_bit.sv
// One toggle cell of the ripple-carry-enable counter chain; q and q_n share one update.
module sync_cnt_bit (
   input  logic MasterClock,
   input  logic reset,
   input  logic cin,
   input  logic clear_n,
   input  logic load,
   input  logic load_bit,
   output logic q,
   output logic q_n,
   output logic cout
);

   // NOTE: sequential state uses non-blocking assignments so every cell samples pre-edge values.
   always_ff @(posedge MasterClock) begin
      if (reset || !clear_n) begin
         q   <= 1'b0;
         q_n <= 1'b1;
      end else if (load) begin
         q   <= load_bit;
         q_n <= ~load_bit;
      end else if (cin) begin
         q   <= ~q;
         q_n <= q;
      end
   end

   assign cout = cin & q;

endmodule

// File: rtl/slip_sync_counter.sv
// Programmable synchronous up-counter with terminal-count register, free-run and one-shot modes.
module slip_sync_counter
   import slip_counter_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             MasterClock,
   input  logic             reset,
   input  logic             cnt_en,
   input  logic             cll,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             tc_wr,
   input  logic [WIDTH-1:0] tc_val,
   input  logic [1:0]       mode,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] tc_reg;
   logic [WIDTH:0]   carry;
   logic             count_now;
   logic             wrap;
   logic             clear_n;
   logic             carry_unused;

   // A wrap is a count at tc_reg that neither a clear nor a load overrides.
   assign count_now = (state == RUN) && mode_active(mode) && cnt_en;
   assign wrap      = count_now && (q == tc_reg) && cll && !ld;
   assign clear_n   = cll && !wrap;
   assign carry[0]  = count_now;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sync_cnt_bit u_bit (
         .MasterClock (MasterClock),
         .reset       (reset),
         .cin         (carry[i]),
         .clear_n     (clear_n),
         .load        (ld),
         .load_bit    (ld_val[i]),
         .q           (q[i]),
         .q_n         (q_n[i]),
         .cout        (carry[i+1])
      );
   end

   assign carry_unused = carry[WIDTH];

   always_ff @(posedge MasterClock) begin
      if (reset) begin
         state  <= IDLE;
         tc_reg <= '1;
         tc     <= 1'b0;
      end else begin
         state <= state_nxt;
         tc    <= wrap;
         if (tc_wr) tc_reg <= tc_val;
      end
   end

   // NOTE: next state defaults to the current state first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start && mode_active(mode)) state_nxt = RUN;
         RUN: begin
            if (!mode_active(mode))                state_nxt = IDLE;
            else if (wrap && mode == MODE_ONESHOT) state_nxt = DONE;
         end
         DONE: begin
            if (!cll)                              state_nxt = IDLE;
            else if (start && mode_active(mode))   state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_slip_sync_counter.sv
// Directed self-checking bench for slip_sync_counter at the default width of 9.
module tb_slip_sync_counter;
   import slip_counter_pkg::*;

   localparam int W   = 9;
   localparam int MAX = (1 << W) - 1;

   logic         MasterClock = 1'b0;
   logic         reset = 1'b1;
   logic         cnt_en = 1'b0;
   logic         cll = 1'b1;
   logic         ld = 1'b0;
   logic [W-1:0] ld_val = '0;
   logic         tc_wr = 1'b0;
   logic [W-1:0] tc_val = '0;
   logic [1:0]   mode = MODE_STOP;
   logic         start = 1'b0;
   logic [W-1:0] q;
   logic [W-1:0] q_n;
   logic         tc;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   slip_sync_counter #(.WIDTH(W)) dut (
      .MasterClock (MasterClock),
      .reset       (reset),
      .cnt_en      (cnt_en),
      .cll         (cll),
      .ld          (ld),
      .ld_val      (ld_val),
      .tc_wr       (tc_wr),
      .tc_val      (tc_val),
      .mode        (mode),
      .start       (start),
      .q           (q),
      .q_n         (q_n),
      .tc          (tc),
      .busy        (busy),
      .done        (done)
   );

   always #5 MasterClock = ~MasterClock;

   // Advance one rising edge and settle 1 ns past it before sampling or driving.
   task automatic step();
      @(posedge MasterClock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (q !== 9'd0 || q_n !== 9'h1FF || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset q=%0d q_n=%h tc=%b busy=%b done=%b want q=0 q_n=1ff tc=0 busy=0 done=0",
                  q, q_n, tc, busy, done);
      end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      int exp_q;
      tc_wr = 1'b1; tc_val = 9'd4;
      step();
      tc_wr = 1'b0; mode = MODE_FREE; start = 1'b1;
      step();
      checks++;
      if (busy !== 1'b1 || q !== 9'd0) begin
         errors++;
         $display("FAIL free_start busy=%b q=%0d want busy=1 q=0", busy, q);
      end
      start = 1'b0; cnt_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         exp_q = (i + 1) % 5;
         checks++;
         if (q !== exp_q[W-1:0] || q_n !== ~exp_q[W-1:0] || tc !== (exp_q == 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL free_run[%0d] q=%0d q_n=%h tc=%b busy=%b want q=%0d tc=%b busy=1",
                     i, q, q_n, tc, busy, exp_q, exp_q == 0);
         end
      end
      mode = MODE_STOP; cnt_en = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || q !== 9'd0) begin
         errors++;
         $display("FAIL free_stop busy=%b q=%0d want busy=0 q=0", busy, q);
      end
   endtask

   task automatic test_oneshot();
      tc_wr = 1'b1; tc_val = 9'd2; mode = MODE_ONESHOT; start = 1'b1;
      step();
      tc_wr = 1'b0; start = 1'b0; cnt_en = 1'b1;
      step();
      step();
      checks++;
      if (q !== 9'd2 || tc !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_pre q=%0d tc=%b busy=%b want q=2 tc=0 busy=1", q, tc, busy);
      end
      step();
      checks++;
      if (q !== 9'd0 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_tc q=%0d tc=%b done=%b busy=%b want q=0 tc=1 done=1 busy=0",
                  q, tc, done, busy);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (q !== 9'd0 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_hold[%0d] q=%0d tc=%b done=%b busy=%b want q=0 tc=0 done=1 busy=0",
                     i, q, tc, done, busy);
         end
      end
      start = 1'b1;
      step();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== 9'd0) begin
         errors++;
         $display("FAIL oneshot_restart busy=%b done=%b q=%0d want busy=1 done=0 q=0", busy, done, q);
      end
      start = 1'b0;
      step();
      checks++;
      if (q !== 9'd1) begin
         errors++;
         $display("FAIL oneshot_resume q=%0d want 1", q);
      end
      mode = MODE_STOP;
      step();
      checks++;
      if (q !== 9'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_stop q=%0d busy=%b want q=1 busy=0", q, busy);
      end
   endtask

   task automatic test_clear_load_priority();
      mode = MODE_FREE; start = 1'b1; cnt_en = 1'b0;
      step();
      start = 1'b0; cnt_en = 1'b1;
      step();
      checks++;
      if (q !== 9'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL prio_setup q=%0d busy=%b want q=2 busy=1", q, busy);
      end
      cll = 1'b0; ld = 1'b1; ld_val = 9'd7;
      step();
      checks++;
      if (q !== 9'd0 || q_n !== 9'h1FF || tc !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL prio_clear q=%0d q_n=%h tc=%b busy=%b want q=0 q_n=1ff tc=0 busy=1",
                  q, q_n, tc, busy);
      end
      cll = 1'b1; ld = 1'b0;
      step();
      checks++;
      if (q !== 9'd1 || tc !== 1'b0) begin
         errors++;
         $display("FAIL prio_after_clear q=%0d tc=%b want q=1 tc=0", q, tc);
      end
      step();
      ld = 1'b1;
      step();
      checks++;
      if (q !== 9'd7 || tc !== 1'b0) begin
         errors++;
         $display("FAIL prio_load q=%0d tc=%b want q=7 tc=0", q, tc);
      end
      ld = 1'b0;
   endtask

   task automatic test_wrap_load();
      logic [W-1:0] exp_q [6];
      logic         exp_tc [6];
      exp_q  = '{9'd511, 9'd0, 9'd1, 9'd2, 9'd3, 9'd0};
      exp_tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tc_wr = 1'b1; tc_val = 9'd3; ld = 1'b1; ld_val = 9'd510;
      step();
      tc_wr = 1'b0; ld = 1'b0;
      checks++;
      if (q !== 9'd510) begin
         errors++;
         $display("FAIL wrap_load q=%0d want 510", q);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (q !== exp_q[i] || tc !== exp_tc[i]) begin
            errors++;
            $display("FAIL wrap_seq[%0d] q=%0d tc=%b want q=%0d tc=%b", i, q, tc, exp_q[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_cnt_en_toggle();
      logic [W-1:0] exp_q [8];
      logic         exp_tc [8];
      exp_q  = '{9'd1, 9'd1, 9'd0, 9'd0, 9'd1, 9'd1, 9'd0, 9'd0};
      exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tc_wr = 1'b1; tc_val = 9'd1; cnt_en = 1'b0;
      step();
      tc_wr = 1'b0;
      checks++;
      if (q !== 9'd0 || tc !== 1'b0) begin
         errors++;
         $display("FAIL toggle_setup q=%0d tc=%b want q=0 tc=0", q, tc);
      end
      for (int i = 0; i < 8; i++) begin
         cnt_en = (i % 2 == 0);
         step();
         checks++;
         if (q !== exp_q[i] || q_n !== ~exp_q[i] || tc !== exp_tc[i]) begin
            errors++;
            $display("FAIL toggle[%0d] q=%0d q_n=%h tc=%b want q=%0d tc=%b",
                     i, q, q_n, tc, exp_q[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_reset_mid_count();
      tc_wr = 1'b1; tc_val = 9'd9; ld = 1'b1; ld_val = 9'd5; cnt_en = 1'b0;
      step();
      tc_wr = 1'b0; ld = 1'b0;
      checks++;
      if (q !== 9'd5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset_setup q=%0d busy=%b want q=5 busy=1", q, busy);
      end
      reset = 1'b1; cnt_en = 1'b1;
      step();
      reset = 1'b0; cnt_en = 1'b0;
      checks++;
      if (q !== 9'd0 || q_n !== 9'h1FF || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midreset q=%0d q_n=%h busy=%b tc=%b done=%b want q=0 q_n=1ff busy=0 tc=0 done=0",
                  q, q_n, busy, tc, done);
      end
      mode = MODE_FREE; start = 1'b1;
      step();
      start = 1'b0; cnt_en = 1'b1;
      for (int i = 1; i <= MAX; i++) begin
         step();
         checks++;
         if (q !== i[W-1:0] || tc !== 1'b0) begin
            errors++;
            $display("FAIL midreset_count q=%0d tc=%b want q=%0d tc=0", q, tc, i);
         end
      end
      step();
      checks++;
      if (q !== 9'd0 || tc !== 1'b1) begin
         errors++;
         $display("FAIL midreset_tc q=%0d tc=%b want q=0 tc=1 (tc_reg back to all ones)", q, tc);
      end
      cnt_en = 1'b0; mode = MODE_STOP;
   endtask

   initial begin
      #1;
      test_reset();
      test_free_run();
      test_oneshot();
      test_clear_load_priority();
      test_wrap_load();
      test_cnt_en_toggle();
      test_reset_mid_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/slip_sync_counter.md
# slip_sync_counter

Programmable synchronous up-counter for the Slipstream timing chain, the stage directly downstream of the bit-0 clear/count cell. It extends that single toggling bit into a WIDTH-bit counter with:
- an active-low synchronous clear;
- a parallel load;
- a programmable terminal count;
- free-run and one-shot modes.

It produces the registered count, its complement, and a one-cycle terminal-count strobe for the video and DMA timing logic.

## Interface
Parameters:
- WIDTH, 9, counter width in bits (2..16)

Ports:
- MasterClock  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- cnt_en  in  1  count-enable strobe; one count per cycle when high
- cll  in  1  active-low synchronous clear of the count
- ld  in  1  parallel load strobe
- ld_val  in  WIDTH  value loaded when ld=1
- tc_wr  in  1  write strobe for the terminal-count register
- tc_val  in  WIDTH  terminal-count value written when tc_wr=1
- mode  in  2  operating mode: 00 stop, 01 free-run, 10 one-shot, 11 reserved (treated as 00)
- start  in  1  start request
- q  out  WIDTH  registered count
- q_n  out  WIDTH  bitwise complement of q, registered identically
- tc  out  1  terminal-count strobe, one cycle wide
- busy  out  1  high in state RUN
- done  out  1  high in state DONE

## Operation
- Reset values: q=0, q_n=all ones, tc=0, busy=0, done=0, tc_reg=all ones, state=IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with mode 01 or 10 moves to RUN.
  - start with mode 00 or 11 is ignored.
  - q holds.
- RUN, on a cycle with cnt_en=1:
  - If q≠tc_reg, q increments modulo 2^WIDTH.
  - If q==tc_reg, q becomes 0 and tc=1 on the same edge.
  - After a terminal count, mode 01 stays in RUN; mode 10 moves to DONE.
- RUN with mode 00 or 11 sampled: moves to IDLE and q holds. Mode is sampled every cycle.
- DONE:
  - q holds at 0.
  - start=1 with mode 01 or 10 moves to RUN.
  - cll=0 moves to IDLE.
- start while in RUN is ignored.
- Count-update priority, highest first: reset, cll=0 (q←0), ld=1 (q←ld_val), RUN and cnt_en (count).
  - tc is never asserted on a cycle where clear or load wins.
- Loads and clears are honoured in every state.
  - A load in IDLE or DONE does not change state.
  - cll=0 changes state only DONE→IDLE.
- tc_wr updates tc_reg on any cycle. The new value takes effect for the compare on the next cycle, not the same cycle.
- A loaded value above tc_reg counts through 2^WIDTH−1, wraps to 0 without tc, then counts up to tc_reg.
- tc_reg=0 in RUN with cnt_en held high gives tc on every cycle, with q staying 0 (divide-by-1).
- q_n always equals ~q. Both are driven from the same register update and never diverge.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- start→busy latency is 1 cycle. The first count happens on the edge after busy rises, provided cnt_en=1.
- tc rises on the edge where q wraps to 0 and falls on the next edge unless another wrap occurs.
- In mode 10, done rises on the same edge as tc and busy falls on that same edge.
- A count period is tc_reg+1 enabled cycles. cnt_en=0 cycles stretch the period without affecting the count.
- Reset asserted mid-count: on the next edge all outputs return to their reset values, including tc_reg.

## Structure
- Package slip_counter_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - mode constants MODE_STOP=2'b00, MODE_FREE=2'b01, MODE_ONESHOT=2'b10.
- Sub-module sync_cnt_bit: one toggle cell per bit, instantiated WIDTH times in a ripple-carry-enable chain.
  - Inputs: MasterClock, reset, carry-in, clear_n, load, load bit.
  - Outputs: q, q_n, carry-out.
- The top level holds the FSM, tc_reg, the compare and the tc register.

## Test plan
- Reset, tc_wr with tc_val=4, mode=01, start, cnt_en held high → q steps 0,1,2,3,4,0,…; tc high exactly when q returns to 0, every 5 cycles; busy=1 throughout.
- mode=10, tc_reg=2, start, cnt_en high → tc once; done=1 and busy=0 on the same edge; q stays 0 for 10 further cycles; a second start resumes counting.
- cll=0 and ld=1 with ld_val=7 in the same cycle while RUN at q==tc_reg → q=0, tc=0; the next cycle counts from 0.
- WIDTH=9, tc_reg=3, ld_val=510 in RUN → q steps 510,511,0,1,2,3,0; tc fires only on the 3→0 wrap.
- cnt_en toggled 1,0,1,0 with tc_reg=1 → a period of 4 clocks; q holds on cnt_en=0 cycles; q_n==~q on every cycle.
- reset pulsed while q=5 in RUN → next cycle q=0, q_n=all ones, busy=0, tc_reg=all ones; start then counts to 2^WIDTH−1 before the first tc.
